sd_burst_arbiter: RTL and testbench



---
 rtl/sd_arb_pkg.sv | 16 +
 rtl/sd_ring_addr.sv | 28 ++
 rtl/sd_burst_arbiter.sv | 157 +++++++++++++++
 tb/tb_sd_burst_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared state encoding, grant constants and clog2 helper for the SDRAM burst arbiter
package sd_arb_pkg;

  typedef enum logic [2:0] {FLUSH, WAIT_BUSY, IDLE, ISSUE, RUN} state_t;

  localparam logic GNT_WR = 1'b1;
  localparam logic GNT_RD = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sd_ring_addr.sv
// rtl/sd_ring_addr.sv - BURST_LEN-step ring address counter wrapping at BASE_ADDR+FRAME_WORDS
module sd_ring_addr #(
  parameter int ADDR_WIDTH  = 24,
  parameter int BURST_LEN   = 64,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH:0]   STEP = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   WRAP = (ADDR_WIDTH+1)'(BASE_ADDR + FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  // One extra bit so the ring end compares correctly when it equals 2**ADDR_WIDTH
  logic [ADDR_WIDTH:0] next_addr;
  assign next_addr = {1'b0, addr} + STEP;

  always_ff @(posedge clk) begin
    if (rst || clear) addr <= BASE;
    else if (step)    addr <= (next_addr == WRAP) ? BASE : next_addr[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/sd_burst_arbiter.sv
// rtl/sd_burst_arbiter.sv - write/read SDRAM burst scheduler with ring fill tracking and FIFO flush sequencing
// SD_ARB_FIXED_PRIO_EN: when defined, write always wins ties instead of round-robin.
module sd_burst_arbiter
  import sd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int BURST_LEN      = 64,
  parameter int WR_COUNT_WIDTH = 10,
  parameter int RD_COUNT_WIDTH = 10,
  parameter int RD_DEPTH       = 1024,
  parameter int BASE_ADDR      = 0,
  parameter int FRAME_WORDS    = 1048576,
  parameter int RST_CYCLES     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      fifo_reset,
  input  logic                      fifo_busy,
  input  logic [WR_COUNT_WIDTH-1:0] wfifo_usedw,
  input  logic [RD_COUNT_WIDTH-1:0] rfifo_usedw,
  input  logic                      rd_enable,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_write,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  output logic [clog2(BURST_LEN):0] cmd_len,
  input  logic                      burst_done,
  output logic                      busy
);

  localparam int LEN_W = clog2(BURST_LEN) + 1;
  localparam int CNT_W = clog2(RST_CYCLES) + 1;
  localparam logic [ADDR_WIDTH:0]     FILL_STEP   = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]     FILL_WR_MAX = (ADDR_WIDTH+1)'(FRAME_WORDS - BURST_LEN);
  localparam logic [WR_COUNT_WIDTH:0] WR_MIN      = (WR_COUNT_WIDTH+1)'(BURST_LEN);
  localparam logic [RD_COUNT_WIDTH:0] RD_MAX      = (RD_COUNT_WIDTH+1)'(RD_DEPTH - BURST_LEN);
  localparam logic [CNT_W-1:0]        CNT_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]   BASE        = ADDR_WIDTH'(BASE_ADDR);

  state_t                state;
  logic [CNT_W-1:0]      flush_cnt;
  logic                  flush_pend;
  logic [ADDR_WIDTH:0]   fill;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  wr_elig, rd_elig, grant_wr, accept, ring_clear;

  assign cmd_len    = LEN_W'(BURST_LEN);
  assign accept     = (state == ISSUE) && cmd_ready;
  assign ring_clear = (state == FLUSH);

  assign wr_elig = ({1'b0, wfifo_usedw} >= WR_MIN) && (fill <= FILL_WR_MAX);
  assign rd_elig = rd_enable && (fill >= FILL_STEP) && ({1'b0, rfifo_usedw} <= RD_MAX);

`ifdef SD_ARB_FIXED_PRIO_EN
  assign grant_wr = wr_elig;
`else
  // Remembers the last accepted direction; reset to read so write takes the first tie
  logic last_gnt;
  assign grant_wr = wr_elig && (!rd_elig || last_gnt == GNT_RD);

  always_ff @(posedge clk) begin
    if (rst)         last_gnt <= GNT_RD;
    else if (accept) last_gnt <= cmd_write ? GNT_WR : GNT_RD;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || ring_clear) fill <= '0;
    else if (accept)       fill <= cmd_write ? fill + FILL_STEP : fill - FILL_STEP;
  end

  sd_ring_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS)
  ) u_wr_addr (
    .clk(clk), .rst(rst), .clear(ring_clear), .step(accept && cmd_write), .addr(wr_addr)
  );

  sd_ring_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS)
  ) u_rd_addr (
    .clk(clk), .rst(rst), .clear(ring_clear), .step(accept && !cmd_write), .addr(rd_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      fifo_reset <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= BASE;
      busy       <= 1'b1;
    end else begin
      case (state)
        FLUSH: begin
          flush_pend <= 1'b0;
          if (flush_cnt == CNT_LAST) begin
            state      <= WAIT_BUSY;
            fifo_reset <= 1'b0;
            flush_cnt  <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (frame_start) begin
            state      <= FLUSH;
            fifo_reset <= 1'b1;
          end else if (!fifo_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (frame_start) begin
            state      <= FLUSH;
            fifo_reset <= 1'b1;
            busy       <= 1'b1;
          end else if (wr_elig || rd_elig) begin
            state     <= ISSUE;
            cmd_valid <= 1'b1;
            cmd_write <= grant_wr;
            cmd_addr  <= grant_wr ? wr_addr : rd_addr;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // A pending command is never dropped; a frame start waits for its burst to finish
          if (frame_start) flush_pend <= 1'b1;
          if (cmd_ready) begin
            state     <= RUN;
            cmd_valid <= 1'b0;
          end
        end
        RUN: begin
          if (burst_done) begin
            if (flush_pend || frame_start) begin
              state      <= FLUSH;
              fifo_reset <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (frame_start) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_burst_arbiter.sv
// tb/tb_sd_burst_arbiter.sv - directed self-checking bench for sd_burst_arbiter (ring of 256 words)
module tb_sd_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst, frame_start, fifo_reset, fifo_busy, rd_enable;
  logic        cmd_valid, cmd_ready, cmd_write, burst_done, busy;
  logic [9:0]  wfifo_usedw, rfifo_usedw;
  logic [23:0] cmd_addr;
  logic [6:0]  cmd_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic        t3_w [4];
  logic [23:0] t3_a [4];
  logic [23:0] t5_a;

  always #5 clk = ~clk;

  sd_burst_arbiter #(.FRAME_WORDS(256)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .fifo_reset(fifo_reset),
    .fifo_busy(fifo_busy), .wfifo_usedw(wfifo_usedw), .rfifo_usedw(rfifo_usedw),
    .rd_enable(rd_enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .burst_done(burst_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for a command, compare it, accept it, optionally frame_start in RUN, then finish it
  task automatic burst(input logic exp_w, input logic [23:0] exp_a, input string tag,
                       input logic fs, input logic exp_flush);
    int n;
    n = 0;
    while (!cmd_valid && n < 60) begin @(negedge clk); n++; end
    check({tag, " valid"}, {31'd0, cmd_valid}, 32'd1);
    check({tag, " write"}, {31'd0, cmd_write}, {31'd0, exp_w});
    check({tag, " addr"}, {8'd0, cmd_addr}, {8'd0, exp_a});
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    check({tag, " drop"}, {31'd0, cmd_valid}, 32'd0);
    if (fs) begin frame_start = 1'b1; @(negedge clk); frame_start = 1'b0; end
    burst_done = 1'b1; @(negedge clk); burst_done = 1'b0;
    check({tag, " flush"}, {31'd0, fifo_reset}, {31'd0, exp_flush});
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin @(negedge clk); if (cmd_valid) seen = 1'b1; end
    check({tag, " no cmd"}, {31'd0, seen}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  cnt;
    logic seen, busy_low, dropped;

`ifdef SD_ARB_FIXED_PRIO_EN
    t3_w = '{1'b1, 1'b1, 1'b0, 1'b1};
    t3_a = '{24'd128, 24'd192, 24'd0, 24'd0};
    t5_a = 24'd64;
`else
    t3_w = '{1'b0, 1'b1, 1'b0, 1'b1};
    t3_a = '{24'd0, 24'd128, 24'd64, 24'd192};
    t5_a = 24'd128;
`endif

    rst = 1'b1; frame_start = 1'b0; fifo_busy = 1'b1; rd_enable = 1'b0;
    cmd_ready = 1'b0; burst_done = 1'b0; wfifo_usedw = 10'd64; rfifo_usedw = 10'd0;
    repeat (3) @(negedge clk);
    check("rst fifo_reset", {31'd0, fifo_reset}, 32'd1);
    check("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst cmd_write", {31'd0, cmd_write}, 32'd0);
    check("rst cmd_addr", {8'd0, cmd_addr}, 32'd0);
    check("rst cmd_len", {25'd0, cmd_len}, 32'd64);
    check("rst busy", {31'd0, busy}, 32'd1);

    // Flush length counted from the release cycle
    rst = 1'b0; cnt = 0; seen = 1'b0;
    while (fifo_reset && cnt < 40) begin
      cnt++;
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
    end
    check("t1 flush cycles", cnt, 32'd16);
    busy_low = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
      if (!busy) busy_low = 1'b1;
    end
    check("t1 busy held", {31'd0, busy_low}, 32'd0);
    fifo_busy = 1'b0;
    @(negedge clk);
    check("t1 idle busy", {31'd0, busy}, 32'd0);
    check("t1 early cmd", {31'd0, seen | cmd_valid}, 32'd0);
    @(negedge clk);
    check("t1 cmd latency", {31'd0, cmd_valid}, 32'd1);

    burst(1'b1, 24'd0, "t2 w0", 1'b0, 1'b0);
    wfifo_usedw = 10'd128;
    burst(1'b1, 24'd64, "t2 w64", 1'b0, 1'b0);

    wfifo_usedw = 10'd200; rd_enable = 1'b1; rfifo_usedw = 10'd0;
    for (int i = 0; i < 4; i++) burst(t3_w[i], t3_a[i], $sformatf("t3 b%0d", i), 1'b0, 1'b0);

    // Frame start in RUN, then frame start while a command waits for cmd_ready
    burst(1'b0, t5_a, "t5 run", 1'b1, 1'b1);
    cnt = 0;
    while (!cmd_valid && cnt < 60) begin @(negedge clk); cnt++; end
    check("t5 restart write", {31'd0, cmd_write}, 32'd1);
    check("t5 restart addr", {8'd0, cmd_addr}, 32'd0);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    rd_enable = 1'b0; dropped = 1'b0;
    repeat (4) begin @(negedge clk); if (!cmd_valid) dropped = 1'b1; end
    check("t5 cmd held", {31'd0, dropped}, 32'd0);
    burst(1'b1, 24'd0, "t5 held", 1'b0, 1'b1);

    burst(1'b1, 24'd0, "t4 w0", 1'b0, 1'b0);
    burst(1'b1, 24'd64, "t4 w64", 1'b0, 1'b0);
    burst(1'b1, 24'd128, "t4 w128", 1'b0, 1'b0);
    burst(1'b1, 24'd192, "t4 w192", 1'b0, 1'b0);
    expect_quiet(10, "t4 full stall");
    rd_enable = 1'b1;
    burst(1'b0, 24'd0, "t4 r0", 1'b0, 1'b0);
    burst(1'b1, 24'd0, "t4 wrap w0", 1'b0, 1'b0);

    wfifo_usedw = 10'd0;
    burst(1'b0, 24'd64, "t6 r64", 1'b0, 1'b0);
    burst(1'b0, 24'd128, "t6 r128", 1'b0, 1'b0);
    burst(1'b0, 24'd192, "t6 r192", 1'b0, 1'b0);
    rfifo_usedw = 10'd961;
    expect_quiet(8, "t6 rfifo 961");
    rfifo_usedw = 10'd960;
    burst(1'b0, 24'd0, "t6 rfifo 960", 1'b0, 1'b0);
    expect_quiet(5, "t6 ring empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
